// File: rtl/async_receiver.sv
// rtl/async_receiver.sv - RS-232 8N1 receiver with oversampled framing, error and idle detection
module async_receiver #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 8,
    parameter int IDLE_BITS  = 10
) (
    input  logic       FPGA_CLK1_50,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] RxD_data,
    output logic       RxD_data_ready,
    output logic       framing_error,
    output logic       RxD_idle,
    output logic       RxD_endofpacket
);
    localparam int DIV     = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SW      = $clog2(OVERSAMPLE);
    localparam int GAP_MAX = IDLE_BITS * OVERSAMPLE;
    localparam int GW      = $clog2(GAP_MAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SUB_HALF  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [GW-1:0] GAP_FULL  = GW'(GAP_MAX);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, nextState;
    logic          rxMeta, rxS;
    logic [TW-1:0] tickCnt;
    logic          tick;
    logic [SW-1:0] subCnt;
    logic [2:0]    bitIdx;
    logic [7:0]    shiftReg;
    logic          breakWait;
    logic [GW-1:0] gapCnt;
    logic          byteSeen;
    logic          idlePrev;
    logic          leaveIdle, shiftEn, stopGood, stopBad, eopNow;

    assign tick     = (tickCnt == TICK_LAST);
    assign RxD_idle = (gapCnt == GAP_FULL);
    assign eopNow   = RxD_idle && !idlePrev && byteSeen;

    always_comb begin
        nextState = state;
        leaveIdle = 1'b0;
        shiftEn   = 1'b0;
        stopGood  = 1'b0;
        stopBad   = 1'b0;
        case (state)
            IDLE: begin
                // after a framing error the line must return high before re-arming
                if (!breakWait && !rxS) begin
                    nextState = START;
                    leaveIdle = 1'b1;
                end
            end
            START: begin
                if (tick && subCnt == SUB_HALF)
                    nextState = rxS ? IDLE : DATA;
            end
            DATA: begin
                if (tick && subCnt == SUB_LAST) begin
                    shiftEn = 1'b1;
                    if (bitIdx == 3'd7)
                        nextState = STOP;
                end
            end
            STOP: begin
                if (tick && subCnt == SUB_LAST) begin
                    nextState = IDLE;
                    stopGood  = rxS;
                    stopBad   = !rxS;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state           <= IDLE;
            rxMeta          <= 1'b1;
            rxS             <= 1'b1;
            tickCnt         <= '0;
            subCnt          <= '0;
            bitIdx          <= '0;
            shiftReg        <= '0;
            breakWait       <= 1'b0;
            gapCnt          <= '0;
            byteSeen        <= 1'b0;
            idlePrev        <= 1'b0;
            RxD_data        <= '0;
            RxD_data_ready  <= 1'b0;
            framing_error   <= 1'b0;
            RxD_endofpacket <= 1'b0;
        end else begin
            rxMeta <= RxD;
            rxS    <= rxMeta;
            state  <= nextState;

            // re-phase the tick divider to the start edge
            tickCnt <= (leaveIdle || tick) ? '0 : tickCnt + 1'b1;

            if (state == IDLE || (state == START && nextState != START))
                subCnt <= '0;
            else if (tick)
                subCnt <= subCnt + 1'b1;

            if (state == START)
                bitIdx <= '0;
            else if (shiftEn)
                bitIdx <= bitIdx + 1'b1;

            if (shiftEn)
                shiftReg <= {rxS, shiftReg[7:1]};

            RxD_data_ready <= stopGood;
            framing_error  <= stopBad;
            if (stopGood)
                RxD_data <= shiftReg;

            if (stopBad)
                breakWait <= 1'b1;
            else if (state == IDLE && rxS)
                breakWait <= 1'b0;

            if (state == IDLE && rxS) begin
                if (tick && gapCnt != GAP_FULL)
                    gapCnt <= gapCnt + 1'b1;
            end else begin
                gapCnt <= '0;
            end

            idlePrev        <= RxD_idle;
            RxD_endofpacket <= eopNow;
            if (stopGood)
                byteSeen <= 1'b1;
            else if (eopNow)
                byteSeen <= 1'b0;
        end
    end
endmodule

// File: tb/tb_async_receiver.sv
// tb/tb_async_receiver.sv - directed and randomized frames checked against a line-level byte model
module tb_async_receiver;
    localparam int CLK_FREQ   = 50000000;
    localparam int BAUD       = 115200;
    localparam int OVERSAMPLE = 8;
    localparam int IDLE_BITS  = 10;
    localparam int BIT_CYC    = CLK_FREQ / BAUD;

    logic       clk = 1'b0;
    logic       reset;
    logic       RxD;
    logic [7:0] RxD_data;
    logic       RxD_data_ready;
    logic       framing_error;
    logic       RxD_idle;
    logic       RxD_endofpacket;

    int total = 0;
    int bad   = 0;

    always #10 clk = ~clk;

    async_receiver #(
        .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE), .IDLE_BITS(IDLE_BITS)
    ) dut (
        .FPGA_CLK1_50(clk),
        .reset(reset),
        .RxD(RxD),
        .RxD_data(RxD_data),
        .RxD_data_ready(RxD_data_ready),
        .framing_error(framing_error),
        .RxD_idle(RxD_idle),
        .RxD_endofpacket(RxD_endofpacket)
    );

    logic [7:0] rxQ[$];
    logic [7:0] expQ[$];
    int nReady = 0, nFe = 0, nEop = 0, nOverlap = 0, nIdleInFrame = 0;
    bit frameActive = 1'b0;

    always @(negedge clk) begin
        if (RxD_data_ready) begin
            nReady++;
            rxQ.push_back(RxD_data);
        end
        if (framing_error) nFe++;
        if (RxD_endofpacket) nEop++;
        if (RxD_data_ready && framing_error) nOverlap++;
        if (frameActive && RxD_idle) nIdleInFrame++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // one 8N1 frame at cyc clocks per bit; the model expects the byte only with a good stop bit
    task automatic send_byte(input logic [7:0] b, input int cyc, input logic stopVal);
        logic [9:0] frame;
        frame = {stopVal, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RxD = frame[i];
            if (i == 0) begin
                repeat (8) @(negedge clk);
                frameActive = 1'b1;
                repeat (cyc - 8) @(negedge clk);
            end else begin
                repeat (cyc) @(negedge clk);
            end
        end
        RxD = 1'b1;
        frameActive = 1'b0;
        if (stopVal) expQ.push_back(b);
    endtask

    task automatic drain(input string tag);
        chk({tag, "_count"}, rxQ.size(), expQ.size());
        while (rxQ.size() > 0 && expQ.size() > 0)
            chk({tag, "_byte"}, rxQ.pop_front(), expQ.pop_front());
        rxQ.delete();
        expQ.delete();
    endtask

    initial begin
        int fe0, r0, e0, cnt, idleExp;
        logic [7:0] rb, b96;

        reset = 1'b1;
        RxD   = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_data", RxD_data, 8'h00);
        chk("rst_ready", RxD_data_ready, 1'b0);
        chk("rst_fe", framing_error, 1'b0);
        chk("rst_idle", RxD_idle, 1'b0);
        chk("rst_eop", RxD_endofpacket, 1'b0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        // single byte
        fe0 = nFe;
        send_byte(8'h55, BIT_CYC, 1'b1);
        repeat (10) @(negedge clk);
        drain("b55");
        chk("b55_data", RxD_data, 8'h55);
        chk("b55_fe", nFe, fe0);
        chk("b55_idle_in_frame", nIdleInFrame, 0);

        // back-to-back with zero gap
        rb = 8'($urandom);
        send_byte(8'hA3, BIT_CYC, 1'b1);
        send_byte(8'h00, BIT_CYC, 1'b1);
        send_byte(8'hFF, BIT_CYC, 1'b1);
        send_byte(rb, BIT_CYC, 1'b1);
        repeat (10) @(negedge clk);
        drain("b2b");
        chk("b2b_data", RxD_data, rb);
        chk("b2b_fe", nFe, fe0);
        chk("eop_before_idle", nEop, 0);

        // idle detection and single end-of-packet
        idleExp = IDLE_BITS * BIT_CYC - BIT_CYC / 2 - 10;
        cnt = 0;
        while (!RxD_idle && cnt < 8000) begin
            @(negedge clk);
            cnt++;
        end
        chk("idle_rise_time", (cnt > idleExp - 80 && cnt < idleExp + 80), 1'b1);
        repeat (5) @(negedge clk);
        chk("eop_once", nEop, 1);
        repeat (15000) @(negedge clk);
        chk("eop_no_repeat", nEop, 1);
        chk("idle_held", RxD_idle, 1'b1);

        // framing error followed by a break, then recovery
        fe0 = nFe;
        send_byte(8'h3C, BIT_CYC, 1'b0);
        RxD = 1'b0;
        repeat (20 * BIT_CYC) @(negedge clk);
        chk("fe_pulse", nFe, fe0 + 1);
        drain("fe_noready");
        chk("fe_data_kept", RxD_data, rb);
        RxD = 1'b1;
        repeat (BIT_CYC) @(negedge clk);
        send_byte(8'h81, BIT_CYC, 1'b1);
        repeat (10) @(negedge clk);
        drain("b81");
        chk("b81_fe", nFe, fe0 + 1);

        // short glitch on idle line
        r0 = nReady;
        fe0 = nFe;
        e0 = nEop;
        RxD = 1'b0;
        repeat (100) @(negedge clk);
        RxD = 1'b1;
        repeat (3 * BIT_CYC) @(negedge clk);
        chk("glitch_ready", nReady, r0);
        chk("glitch_fe", nFe, fe0);
        chk("glitch_data", RxD_data, 8'h81);

        // reset midway through bit 4 of 0x96 aborts the frame
        b96 = 8'h96;
        RxD = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            RxD = b96[i];
            repeat (BIT_CYC) @(negedge clk);
        end
        RxD = b96[4];
        repeat (BIT_CYC / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        RxD = 1'b1;
        chk("midrst_data", RxD_data, 8'h00);
        repeat (2 * BIT_CYC) @(negedge clk);
        chk("midrst_ready", nReady, r0);
        send_byte(8'h5A, BIT_CYC, 1'b1);
        repeat (10) @(negedge clk);
        drain("b5A");

        // baud tolerance
        fe0 = nFe;
        send_byte(8'hC6, (BIT_CYC * 100 + 51) / 102, 1'b1);
        repeat (10) @(negedge clk);
        send_byte(8'hC6, (BIT_CYC * 100 + 49) / 98, 1'b1);
        repeat (10) @(negedge clk);
        drain("tol");
        chk("tol_fe", nFe, fe0);
        chk("overlap", nOverlap, 0);
        chk("idle_in_frame", nIdleInFrame, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
